aes_word_host: RTL

- Host-side initiator for the word-serial AES core interface.
- Accepts a 128-bit key and a 128-bit text block from a system master over a valid/ready handshake.
- Serialises both into four 32-bit words with ld, waits for the core's done, then collects four 32-bit text_out words.
- Presents the reassembled 128-bit result over a second valid/ready handshake. Sits between the bus fabric and the AES core.

---
 rtl/aes_word_host_if.sv | 23 ++
 rtl/aes_word_host.sv | 134 +++++++++++++
 2 files changed

// File: rtl/aes_word_host_if.sv
// System-side bus bundle for aes_word_host: key/text request handshake
// and result response handshake.
interface aes_word_host_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_key;
    logic [127:0] in_text;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_text;

    // Bus master offers key/text and consumes the result
    modport master (
        output in_valid, in_key, in_text, out_ready,
        input  in_ready, out_valid, out_text
    );

    // aes_word_host side of the bundle
    modport slave (
        input  in_valid, in_key, in_text, out_ready,
        output in_ready, out_valid, out_text
    );
endinterface

// File: rtl/aes_word_host.sv
// aes_word_host: host-side initiator for a word-serial AES core.
// Takes a 128-bit key/text pair, streams it to the core as four 32-bit
// words, waits for done, gathers four result words and presents them.
// Optional: define AES_HOST_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYCLES without done (pulses timeout, returns to IDLE).
module aes_word_host #(
    parameter int WORDS          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst,
    aes_word_host_if.slave   bus,
    output logic             busy,
    output logic             ld,
    output logic [31:0]      key,
    output logic [31:0]      text_in,
    input  logic             done,
    input  logic [31:0]      text_out,
    output logic             timeout
);
    localparam int WW = $clog2(WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_COLLECT,
        S_OUT
    } state_t;

    state_t state, state_nx;

    // Element 0 of each array is the most significant word ([127:96]).
    logic [0:WORDS-1][31:0] key_r, text_r, res_r;
    logic [31:0]            key_hold, text_hold;
    logic [WW-1:0]          wcnt;
    logic                   last_word;
    logic                   accept;
    logic                   expire;

    assign last_word = (wcnt == WW'(WORDS-1));
    assign accept    = bus.in_valid && (state == S_IDLE);
    assign bus.out_text = res_r;

`ifdef AES_HOST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TW-1:0] tcnt;

    // WAIT-cycle counter; cleared whenever we are outside WAIT
    always_ff @(posedge clk) begin
        if (!rst || state != S_WAIT) tcnt <= '0;
        else                         tcnt <= tcnt + 1'b1;
    end

    // tcnt is 0 on the first WAIT cycle, so this is WAIT cycle TIMEOUT_CYCLES
    assign expire = (state == S_WAIT) && (tcnt == TW'(TIMEOUT_CYCLES-1));
`else
    assign expire = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    // Next-state and status/strobe outputs
    always_comb begin
        state_nx     = state;
        timeout      = 1'b0;
        bus.in_ready = (state == S_IDLE);
        bus.out_valid = (state == S_OUT);
        busy         = (state != S_IDLE);
        ld           = (state == S_LOAD);
        key          = key_hold;
        text_in      = text_hold;
        case (state)
            S_IDLE:    if (accept) state_nx = S_LOAD;
            S_LOAD: begin
                key     = key_r[wcnt];
                text_in = text_r[wcnt];
                if (last_word) state_nx = S_WAIT;
            end
            S_WAIT: begin
                // done on the expiry cycle takes priority over the abort
                if (done) state_nx = S_COLLECT;
                else if (expire) begin
                    timeout  = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_COLLECT: if (last_word) state_nx = S_OUT;
            S_OUT:     if (bus.out_ready) state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // Datapath: capture request, sequence words, gather result
    always_ff @(posedge clk) begin
        if (!rst) begin
            key_r     <= '0;
            text_r    <= '0;
            res_r     <= '0;
            key_hold  <= '0;
            text_hold <= '0;
            wcnt      <= '0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    key_r  <= bus.in_key;
                    text_r <= bus.in_text;
                    wcnt   <= '0;
                end
                S_LOAD: begin
                    wcnt <= wcnt + 1'b1;
                    // keep the core-facing words steady once ld drops
                    if (last_word) begin
                        key_hold  <= key_r[wcnt];
                        text_hold <= text_r[wcnt];
                    end
                end
                S_WAIT: if (done) begin
                    res_r[0] <= text_out;
                    wcnt     <= WW'(1);
                end
                S_COLLECT: begin
                    res_r[wcnt] <= text_out;
                    wcnt        <= wcnt + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
